sl_rx_buffered: RTL and testbench
=================================

// Module: sl_rx_buffered
// PURPOSE
//  Parametrised two-wire serial-line (SL) word receiver: next generation of the SL receive path.
//  Samples async ZEROES/ONES lines at clk, classifies bits at a strobe point, checks length and odd parity,
//  and pushes good words into a FIFO with valid/ready readout. Sits between SL pads and the register/bus block.
// PARAMETERS
//  DATA_W      32   max data bits per word (parity excluded), 1..32
//  STROB_POS   8    cycles after bit start at which lines are sampled, >=2
//  BIT_TMO     64   max cycles a bit pulse may stay asserted before level error
//  GAP_TMO     256  max idle cycles between bits inside a word before length error
//  FIFO_DEPTH  4    received-word FIFO entries, power of 2, >=2
// PORTS
//  clk            in   1        system clock (16 MHz nominal)
//  rst_n          in   1        synchronous reset, active low
//  sl_zeroes_a    in   1        SL zeroes wire, async, idle high
//  sl_ones_a      in   1        SL ones wire, async, idle high
//  cfg_bit_qty    in   6        data bits per word (1..DATA_W), latched at first bit of word
//  cfg_pce        in   1        parity check enable, latched at first bit of word
//  rx_data        out  DATA_W   FIFO head word, LSB = first bit received, zero-extended
//  rx_valid       out  1        FIFO non-empty
//  rx_ready       in   1        pop FIFO head when rx_valid & rx_ready
//  status         out  8        {2'b0, ovf, lef, pef, wlc, busy, wrf}; flags sticky
//  status_clr     in   1        one-cycle pulse clears sticky flags
//  err_pulse      out  1        one-cycle pulse on any parity/length/level error
// BEHAVIOUR
//  - Lines pass a 2-FF synchroniser; all decisions use synced values (2-cycle input latency).
//  - Encoding at strobe: ones=0,zeroes=1 -> bit 1; ones=1,zeroes=0 -> bit 0; both 0 -> stop; both 1 -> level err.
//  - FSM: IDLE -> (either synced line falls) STROBE; STROBE counts cyc_cnt 0..STROB_POS-1, classifies at last count:
//    data bit -> shift in, bit_cnt+1, BIT_END; stop -> word check, BIT_END; both high -> level err, IDLE.
//    BIT_END -> both lines high -> IDLE; cyc_cnt reaching BIT_TMO -> level err, stays BIT_END until idle.
//  - Word check at stop: bit_cnt must equal cfg_bit_qty+1 (data+parity) else wlc; if cfg_pce, ones count over
//    data+parity must be odd else pef. Good word: parity stripped, pushed to FIFO, wrf set.
//  - Any error discards the word: bit_cnt, shift reg cleared; err_pulse asserted one cycle; nothing pushed.
//  - Inter-bit gap: in IDLE with bit_cnt!=0, idle count reaching GAP_TMO -> wlc error, word discarded.
//  - bit_cnt beyond DATA_W+1 saturates; word then fails length check at stop.
//  - busy = bit_cnt!=0 or FSM not IDLE. Push to full FIFO: word dropped, ovf set.
//  - Push and pop same cycle: both performed, including when full (pop frees slot first).
//  - Flag set and status_clr same cycle: set wins.
//  - Reset (any cycle, incl. mid-word): FSM IDLE, counters 0, FIFO empty, rx_valid=0, rx_data=0, status=0,
//    err_pulse=0, synchroniser preset to 1 (idle). No spurious start after reset release.
// CONFIGURATION
//  SL_RX_ERR_CNT_EN defined: adds outputs par_err_cnt, len_err_cnt, lev_err_cnt (16 b each, saturating at
//   16'hFFFF, cleared by reset and status_clr). Undefined: ports and counters absent, all else identical.
// STRUCTURE
//  - Package sl_rx_pkg: FSM state enum, status bit index constants, line-code constants.
//  - Sub-module sl_rx_fifo (WIDTH, DEPTH): synchronous FIFO, full/empty, simultaneous push/pop.
// TESTING
//  - cfg_bit_qty=8, pce=1, send 0xA5+parity(1), stop -> rx_data=0x000000A5, rx_valid=1, wrf=1, no err.
//  - Same word with parity inverted -> pef=1, err_pulse one cycle, rx_valid stays 0.
//  - cfg_bit_qty=8, send 7 bits+parity+stop -> wlc=1; then 12-cycle pulse classifications unaffected next word.
//  - 5 good words, rx_ready=0, FIFO_DEPTH=4 -> 4 stored, ovf=1; pop 4 with rx_ready=1 -> order preserved.
//  - Assert rst_n=0 for 1 cycle mid-word after 3 bits -> all outputs reset; next full word received correctly.
//  - Ones wire held low 70 cycles -> lef=1 at cycle BIT_TMO; with SL_RX_ERR_CNT_EN lev_err_cnt=1.

Source files
------------

// File: rtl/sl_rx_pkg.sv
// Shared types and constants for the SL word receiver: FSM states, status bit
// positions, the two-wire line codes and a saturating counter helper.
package sl_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_BIT_END = 2'd2
    } state_t;

    localparam int SB_WRF  = 0;
    localparam int SB_BUSY = 1;
    localparam int SB_WLC  = 2;
    localparam int SB_PEF  = 3;
    localparam int SB_LEF  = 4;
    localparam int SB_OVF  = 5;

    // Code is {ones, zeroes} as seen at the strobe point.
    typedef enum logic [1:0] {
        LC_STOP  = 2'b00,
        LC_ONE   = 2'b01,
        LC_ZERO  = 2'b10,
        LC_LEVEL = 2'b11
    } line_code_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/sl_rx_fifo.sv
// Synchronous FIFO for received words; head visible combinationally, zero when empty.
// Push on full is accepted only together with a pop (pop frees the slot first).
module sl_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/sl_rx_buffered.sv
// Two-wire SL word receiver: sync, strobe-point classification, length/odd-parity check, word FIFO.
// Optional per-type error counters when SL_RX_ERR_CNT_EN is defined.
module sl_rx_buffered
    import sl_rx_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int STROB_POS  = 8,
    parameter int BIT_TMO    = 64,
    parameter int GAP_TMO    = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sl_zeroes_a,
    input  logic              sl_ones_a,
    input  logic [5:0]        cfg_bit_qty,
    input  logic              cfg_pce,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [7:0]        status,
    input  logic              status_clr,
    output logic              err_pulse
`ifdef SL_RX_ERR_CNT_EN
    ,
    output logic [15:0]       par_err_cnt,
    output logic [15:0]       len_err_cnt,
    output logic [15:0]       lev_err_cnt
`endif
);
    localparam int BW      = $clog2(DATA_W + 3);
    localparam int CNT_MAX = (GAP_TMO > BIT_TMO) ? GAP_TMO : BIT_TMO;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [BW-1:0] BC_SAT    = BW'(DATA_W + 2);
    localparam logic [CW-1:0] STROB_END = CW'(STROB_POS - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TMO - 1);
    localparam logic [CW-1:0] BIT_LIM   = CW'(BIT_TMO);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TMO - 1);

    logic z_s1, z_s2, o_s1, o_s2;
    state_t state, state_nxt;
    logic [CW-1:0]     cyc_cnt, cyc_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] word_dat;
    logic              par_acc;
    logic [5:0]        qty_l;
    logic              pce_l;
    line_code_t        code;
    logic ev_start, ev_bit, ev_stop, ev_lev, ev_gap;
    logic bit_val, len_ok, par_ok, good, clear_word;
    logic wlc_set, pef_set, lev_set, ovf_set, err_any;
    logic wrf, wlc, pef, lef, ovf;
    logic fifo_full, fifo_empty, pop;

    assign code    = line_code_t'({o_s2, z_s2});
    assign bit_val = (code == LC_ONE);

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt;
        ev_start  = 1'b0;
        ev_bit    = 1'b0;
        ev_stop   = 1'b0;
        ev_lev    = 1'b0;
        ev_gap    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!z_s2 || !o_s2) begin
                    state_nxt = ST_STROBE;
                    cyc_nxt   = '0;
                    ev_start  = 1'b1;
                end else if (bit_cnt != '0) begin
                    // Idle time inside a word counts towards the gap limit.
                    if (cyc_cnt == GAP_LAST) begin
                        ev_gap  = 1'b1;
                        cyc_nxt = '0;
                    end else begin
                        cyc_nxt = cyc_cnt + 1'b1;
                    end
                end else begin
                    cyc_nxt = '0;
                end
            end
            ST_STROBE: begin
                cyc_nxt = cyc_cnt + 1'b1;
                if (cyc_cnt == STROB_END) begin
                    case (code)
                        LC_ONE, LC_ZERO: begin
                            ev_bit    = 1'b1;
                            state_nxt = ST_BIT_END;
                        end
                        LC_STOP: begin
                            ev_stop   = 1'b1;
                            state_nxt = ST_BIT_END;
                        end
                        default: begin
                            ev_lev    = 1'b1;
                            state_nxt = ST_IDLE;
                            cyc_nxt   = '0;
                        end
                    endcase
                end
            end
            ST_BIT_END: begin
                if (z_s2 && o_s2) begin
                    state_nxt = ST_IDLE;
                    cyc_nxt   = '0;
                end else if (cyc_cnt < BIT_LIM) begin
                    // Counter parks at BIT_TMO so a stuck line reports once.
                    cyc_nxt = cyc_cnt + 1'b1;
                    ev_lev  = (cyc_cnt == BIT_LAST);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cyc_nxt   = '0;
            end
        endcase
    end

    assign len_ok     = (int'(bit_cnt) == int'(qty_l) + 1) && (int'(bit_cnt) <= DATA_W + 1);
    assign par_ok     = ~pce_l | par_acc;
    assign good       = ev_stop & len_ok & par_ok;
    assign wlc_set    = (ev_stop & ~len_ok) | ev_gap;
    assign pef_set    = ev_stop & ~par_ok;
    assign lev_set    = ev_lev;
    assign err_any    = wlc_set | pef_set | lev_set;
    assign clear_word = ev_stop | err_any;
    assign pop        = rx_valid & rx_ready;
    assign ovf_set    = good & fifo_full & ~pop;

    always_comb begin
        word_dat = '0;
        for (int i = 0; i < DATA_W; i++) begin
            word_dat[i] = shreg[i] & (i < int'(qty_l));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_s1      <= 1'b1;
            z_s2      <= 1'b1;
            o_s1      <= 1'b1;
            o_s2      <= 1'b1;
            state     <= ST_IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            qty_l     <= '0;
            pce_l     <= 1'b0;
            err_pulse <= 1'b0;
            wrf       <= 1'b0;
            wlc       <= 1'b0;
            pef       <= 1'b0;
            lef       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            z_s1    <= sl_zeroes_a;
            z_s2    <= z_s1;
            o_s1    <= sl_ones_a;
            o_s2    <= o_s1;
            state   <= state_nxt;
            cyc_cnt <= cyc_nxt;
            if (ev_start && bit_cnt == '0) begin
                qty_l <= cfg_bit_qty;
                pce_l <= cfg_pce;
            end
            if (clear_word) begin
                bit_cnt <= '0;
                shreg   <= '0;
                par_acc <= 1'b0;
            end else if (ev_bit) begin
                if (int'(bit_cnt) < DATA_W) shreg <= shreg | (DATA_W'(bit_val) << bit_cnt);
                if (bit_cnt != BC_SAT) bit_cnt <= bit_cnt + 1'b1;
                par_acc <= par_acc ^ bit_val;
            end
            err_pulse <= err_any;
            wrf <= good    | (wrf & ~status_clr);
            wlc <= wlc_set | (wlc & ~status_clr);
            pef <= pef_set | (pef & ~status_clr);
            lef <= lev_set | (lef & ~status_clr);
            ovf <= ovf_set | (ovf & ~status_clr);
        end
    end

    always_comb begin
        status          = 8'h00;
        status[SB_WRF]  = wrf;
        status[SB_BUSY] = (bit_cnt != '0) || (state != ST_IDLE);
        status[SB_WLC]  = wlc;
        status[SB_PEF]  = pef;
        status[SB_LEF]  = lef;
        status[SB_OVF]  = ovf;
    end

    sl_rx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (good),
        .push_dat (word_dat),
        .pop      (pop),
        .head_dat (rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rx_valid = ~fifo_empty;

`ifdef SL_RX_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err_cnt <= '0;
            len_err_cnt <= '0;
            lev_err_cnt <= '0;
        end else if (status_clr) begin
            par_err_cnt <= 16'(pef_set);
            len_err_cnt <= 16'(wlc_set);
            lev_err_cnt <= 16'(lev_set);
        end else begin
            par_err_cnt <= sat_inc16(par_err_cnt, pef_set);
            len_err_cnt <= sat_inc16(len_err_cnt, wlc_set);
            lev_err_cnt <= sat_inc16(lev_err_cnt, lev_set);
        end
    end
`endif

endmodule

// File: tb/tb_sl_rx_buffered.sv
// Directed bench for sl_rx_buffered: words driven on the two wires, expected words queued and
// compared at FIFO readout; status, err_pulse and (optionally) error counters checked inline.
module tb_sl_rx_buffered;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sl_zeroes_a;
    logic        sl_ones_a;
    logic [5:0]  cfg_bit_qty;
    logic        cfg_pce;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  status;
    logic        status_clr;
    logic        err_pulse;
`ifdef SL_RX_ERR_CNT_EN
    logic [15:0] par_err_cnt;
    logic [15:0] len_err_cnt;
    logic [15:0] lev_err_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int ep_cnt = 0;
    int e0;
    logic [31:0] exp_q[$];
    logic [31:0] w;

    always #5 clk = ~clk;

    always @(posedge clk) if (err_pulse === 1'b1) ep_cnt++;

    sl_rx_buffered dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sl_zeroes_a (sl_zeroes_a),
        .sl_ones_a   (sl_ones_a),
        .cfg_bit_qty (cfg_bit_qty),
        .cfg_pce     (cfg_pce),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .status      (status),
        .status_clr  (status_clr),
        .err_pulse   (err_pulse)
`ifdef SL_RX_ERR_CNT_EN
        ,
        .par_err_cnt (par_err_cnt),
        .len_err_cnt (len_err_cnt),
        .lev_err_cnt (lev_err_cnt)
`endif
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_sym(input logic o, input logic z);
        sl_ones_a   = o;
        sl_zeroes_a = z;
        tick(12);
        sl_ones_a   = 1'b1;
        sl_zeroes_a = 1'b1;
        tick(4);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_sym(1'b0, 1'b1);
        else   send_sym(1'b1, 1'b0);
    endtask

    // Data LSB first, then odd parity over data+parity (optionally inverted), then stop.
    task automatic send_word(input logic [31:0] d, input int n, input logic flip);
        logic p;
        p = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_bit(d[i]);
            p = p ^ d[i];
        end
        send_bit(p ^ flip);
        send_sym(1'b0, 1'b0);
    endtask

    task automatic clr();
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        int wcyc;
        wcyc = 0;
        while (rx_valid !== 1'b1 && wcyc < 50) begin
            tick(1);
            wcyc++;
        end
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        if (exp_q.size() > 0) check(tag, rx_data, exp_q.pop_front());
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        sl_zeroes_a = 1'b1;
        sl_ones_a   = 1'b1;
        cfg_bit_qty = 6'd8;
        cfg_pce     = 1'b1;
        rx_ready    = 1'b0;
        status_clr  = 1'b0;
        tick(3);
        check("rst_valid",  {31'd0, rx_valid},  32'd0);
        check("rst_data",   rx_data,            32'd0);
        check("rst_status", {24'd0, status},    32'd0);
        check("rst_errp",   {31'd0, err_pulse}, 32'd0);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_status", {24'd0, status}, 32'd0);

        // Good word 0xA5 with parity
        e0 = ep_cnt;
        exp_q.push_back(32'h0000_00A5);
        send_word(32'hA5, 8, 1'b0);
        check("good_status", {24'd0, status}, 32'h01);
        check("good_errp",   ep_cnt - e0,     32'd0);
        pop_check("good_a5");
        check("good_drained", {31'd0, rx_valid}, 32'd0);
        clr();
        check("clr_status", {24'd0, status}, 32'd0);

        // Parity inverted
        e0 = ep_cnt;
        send_word(32'hA5, 8, 1'b1);
        check("pef_status", {24'd0, status},   32'h08);
        check("pef_errp",   ep_cnt - e0,       32'd1);
        check("pef_valid",  {31'd0, rx_valid}, 32'd0);
        clr();

        // Short word, then a normal one
        e0 = ep_cnt;
        send_word(32'h55, 7, 1'b0);
        check("wlc_status", {24'd0, status},   32'h04);
        check("wlc_errp",   ep_cnt - e0,       32'd1);
        check("wlc_valid",  {31'd0, rx_valid}, 32'd0);
        clr();
        exp_q.push_back(32'h0000_003C);
        send_word(32'h3C, 8, 1'b0);
        check("after_wlc_status", {24'd0, status}, 32'h01);
        pop_check("after_wlc_3c");
        clr();

        // Overflow: five words into a four-deep FIFO
        e0 = ep_cnt;
        for (int k = 0; k < 5; k++) begin
            w = 32'($urandom_range(0, 255));
            if (k < 4) exp_q.push_back(w);
            send_word(w, 8, 1'b0);
        end
        check("ovf_status", {24'd0, status},   32'h21);
        check("ovf_errp",   ep_cnt - e0,       32'd0);
        check("ovf_valid",  {31'd0, rx_valid}, 32'd1);
        for (int k = 0; k < 4; k++) pop_check($sformatf("ovf_pop%0d", k));
        check("ovf_drained", {31'd0, rx_valid}, 32'd0);
        clr();

        // Reset mid-word after three bits
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("mid_busy", {24'd0, status}, 32'h02);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midrst_valid",  {31'd0, rx_valid},  32'd0);
        check("midrst_data",   rx_data,            32'd0);
        check("midrst_status", {24'd0, status},    32'd0);
        check("midrst_errp",   {31'd0, err_pulse}, 32'd0);
        e0 = ep_cnt;
        exp_q.push_back(32'h0000_005A);
        send_word(32'h5A, 8, 1'b0);
        check("midrst_good_status", {24'd0, status}, 32'h01);
        pop_check("midrst_5a");
        cfg_bit_qty = 6'd5;
        exp_q.push_back(32'h0000_0013);
        send_word(32'h13, 5, 1'b0);
        pop_check("qty5_13");
        check("midrst_errp_none", ep_cnt - e0, 32'd0);
        cfg_bit_qty = 6'd8;
        clr();

        // Inter-bit gap timeout
        e0 = ep_cnt;
        send_bit(1'b1);
        tick(300);
        check("gap_status", {24'd0, status}, 32'h04);
        check("gap_errp",   ep_cnt - e0,     32'd1);
        clr();

        // Ones wire stuck low
        e0 = ep_cnt;
        sl_ones_a = 1'b0;
        tick(55);
        check("lev_early", {24'd0, status}, 32'h02);
        tick(14);
        check("lev_hit", {24'd0, status}, 32'h12);
        tick(1);
        sl_ones_a = 1'b1;
        tick(5);
        check("lev_status", {24'd0, status}, 32'h10);
        check("lev_errp",   ep_cnt - e0,     32'd1);
`ifdef SL_RX_ERR_CNT_EN
        check("lev_cnt", {16'd0, lev_err_cnt}, 32'd1);
        check("par_cnt", {16'd0, par_err_cnt}, 32'd0);
        check("len_cnt", {16'd0, len_err_cnt}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
